// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetches 16-bit instructions from a byte-wide instruction memory. Each
//   instruction is stored big-endian: the high byte sits at the even address
//   and the low byte at the next address. The block owns the PC and issues
//   two byte reads per instruction. It presents the assembled word to decode
//   over a valid/ready handshake. It also handles branch redirects and halt
//   detection.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, leaves IDLE and begins fetching at the PC
//   mem_rd_en    memory read strobe
//   mem_addr     memory byte address
//   mem_rdata    read data, valid the cycle after mem_rd_en
//   instr_valid  instr_data / instr_pc hold a valid instruction
//   instr_ready  decode accepts the presented instruction
//   instr_data   assembled instruction {hi, lo}
//   instr_pc     address of the instruction's high byte
//   br_valid     redirect request
//   br_target    redirect address
//   addr_err     (only with FETCH_ALIGN_CHECK_EN) odd redirect target seen
//   halted       HALT_WORD fetched, fetch stopped
//   busy         high in every state except IDLE and HALTED
//
// Build option
//   FETCH_ALIGN_CHECK_EN: an odd redirect target is refused. The block sets
//   the sticky addr_err flag and halts. Without this option, odd targets are
//   fetched unaligned.

module fetch_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       HALT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              addr_err,
`else
`endif
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    CAP,
    PRESENT,
    HALTED
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [7:0]        hi_byte_reg;
  logic              redirect_ok;
  logic [15:0]       word_next;

  // Redirects are honoured only while a fetch is in progress.
  assign redirect_ok = (state_reg == RD_HI) || (state_reg == RD_LO) ||
                       (state_reg == CAP)   || (state_reg == PRESENT);

  assign word_next = {hi_byte_reg, mem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      hi_byte_reg <= 8'h00;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_data  <= 16'h0000;
      instr_pc    <= '0;
      halted      <= 1'b0;
      busy        <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      addr_err    <= 1'b0;
`else
`endif
    end else begin
      // Outputs are registered, so each branch sets up the values for the
      // state being entered.
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RD_HI;
            mem_rd_en <= 1'b1;
            mem_addr  <= pc_reg;
            busy      <= 1'b1;
          end
        end
        RD_HI: begin
          state_reg <= RD_LO;
          mem_rd_en <= 1'b1;
          mem_addr  <= pc_reg + ADDR_W'(1);
        end
        RD_LO: begin
          hi_byte_reg <= mem_rdata;
          state_reg   <= CAP;
          mem_rd_en   <= 1'b0;
        end
        CAP: begin
          // The low byte is used straight off the bus. It is never needed
          // after this cycle.
          if (word_next == HALT_WORD) begin
            state_reg <= HALTED;
            halted    <= 1'b1;
            busy      <= 1'b0;
          end else begin
            instr_data  <= word_next;
            instr_pc    <= pc_reg;
            instr_valid <= 1'b1;
            state_reg   <= PRESENT;
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc_reg      <= pc_reg + ADDR_W'(2);
            state_reg   <= RD_HI;
            mem_rd_en   <= 1'b1;
            mem_addr    <= pc_reg + ADDR_W'(2);
          end
        end
        HALTED: begin
          mem_rd_en <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          mem_rd_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      // A redirect is written last so that it overrides the case above. It
      // beats a same-cycle handshake and halt detection. Any half-read
      // instruction is dropped because the fetch restarts at RD_HI.
      if (br_valid && redirect_ok) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (br_target[0]) begin
          addr_err    <= 1'b1;
          instr_valid <= 1'b0;
          state_reg   <= HALTED;
          halted      <= 1'b1;
          busy        <= 1'b0;
          mem_rd_en   <= 1'b0;
        end else begin
          pc_reg      <= br_target;
          instr_valid <= 1'b0;
          state_reg   <= RD_HI;
          mem_rd_en   <= 1'b1;
          mem_addr    <= br_target;
        end
`else
        pc_reg      <= br_target;
        instr_valid <= 1'b0;
        state_reg   <= RD_HI;
        mem_rd_en   <= 1'b1;
        mem_addr    <= br_target;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a registered-read byte memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, instr_ready, br_valid;
  logic        mem_rd_en, instr_valid, halted, busy;
  logic [7:0]  mem_addr, instr_pc, br_target;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] instr_data;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .halted      (halted),
`ifdef FETCH_ALIGN_CHECK_EN
    .addr_err    (addr_err),
`endif
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_addr"},  32'(mem_addr), 0);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_data"},  32'(instr_data), 0);
    chk({tag, "_pc"},    32'(instr_pc), 0);
    chk({tag, "_halted"},32'(halted), 0);
    chk({tag, "_busy"},  32'(busy), 0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, "_addr_err"}, 32'(addr_err), 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    mem[8'h00] = 8'h21; mem[8'h01] = 8'hFE; mem[8'h02] = 8'h22; mem[8'h03] = 8'hFB;
    mem[8'h28] = 8'h55; mem[8'h29] = 8'h66;
    mem[8'h3E] = 8'h00; mem[8'h3F] = 8'h00;
    mem[8'hFE] = 8'hAB; mem[8'hFF] = 8'hCD;

    reset = 1'b1; start = 1'b0; instr_ready = 1'b0; br_valid = 1'b0; br_target = 8'h00;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_rd_en", 32'(mem_rd_en), 0);
    chk("idle_busy", 32'(busy), 0);

    // Basic fetch of two instructions with ready held high.
    start = 1'b1; instr_ready = 1'b1;
    tick(); start = 1'b0;
    chk("f1_hi_en", 32'(mem_rd_en), 1);
    chk("f1_hi_addr", 32'(mem_addr), 8'h00);
    chk("f1_busy", 32'(busy), 1);
    tick();
    chk("f1_lo_en", 32'(mem_rd_en), 1);
    chk("f1_lo_addr", 32'(mem_addr), 8'h01);
    tick();
    chk("f1_cap_en", 32'(mem_rd_en), 0);
    chk("f1_cap_valid", 32'(instr_valid), 0);
    tick();
    chk("f1_valid", 32'(instr_valid), 1);
    chk("f1_data", 32'(instr_data), 16'h21FE);
    chk("f1_pc", 32'(instr_pc), 8'h00);
    tick();
    chk("f2_hi_addr", 32'(mem_addr), 8'h02);
    chk("f2_hi_en", 32'(mem_rd_en), 1);
    chk("f2_hi_valid", 32'(instr_valid), 0);
    tick();
    chk("f2_lo_addr", 32'(mem_addr), 8'h03);
    tick();
    tick();
    chk("f2_valid", 32'(instr_valid), 1);
    chk("f2_data", 32'(instr_data), 16'h22FB);
    chk("f2_pc", 32'(instr_pc), 8'h02);

    // Redirect back to 0 from PRESENT, then stall decode for 5 cycles.
    instr_ready = 1'b0; br_valid = 1'b1; br_target = 8'h00;
    tick(); br_valid = 1'b0;
    chk("br0_addr", 32'(mem_addr), 8'h00);
    chk("br0_en", 32'(mem_rd_en), 1);
    chk("br0_valid", 32'(instr_valid), 0);
    tick(); tick(); tick();
    chk("st_valid0", 32'(instr_valid), 1);
    chk("st_data0", 32'(instr_data), 16'h21FE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_data", 32'(instr_data), 16'h21FE);
      chk("stall_pc", 32'(instr_pc), 8'h00);
      chk("stall_rd_en", 32'(mem_rd_en), 0);
    end
    instr_ready = 1'b1;
    tick();
    chk("rel_addr", 32'(mem_addr), 8'h02);
    chk("rel_en", 32'(mem_rd_en), 1);
    tick();
    chk("rel_lo_addr", 32'(mem_addr), 8'h03);

    // Redirect during RD_LO: the half-read instruction is dropped.
    br_valid = 1'b1; br_target = 8'h28;
    tick(); br_valid = 1'b0;
    chk("brlo_addr", 32'(mem_addr), 8'h28);
    chk("brlo_valid", 32'(instr_valid), 0);
    tick();
    chk("brlo_lo_addr", 32'(mem_addr), 8'h29);
    tick();
    chk("brlo_cap_valid", 32'(instr_valid), 0);
    tick();
    chk("brlo_data", 32'(instr_data), 16'h5566);
    chk("brlo_pc", 32'(instr_pc), 8'h28);

    // Redirect coincident with the handshake: the target wins, not pc+2.
    br_valid = 1'b1; br_target = 8'hFE;
    tick(); br_valid = 1'b0;
    chk("brhs_addr", 32'(mem_addr), 8'hFE);
    chk("brhs_valid", 32'(instr_valid), 0);
    tick();
    chk("wrap_lo_addr", 32'(mem_addr), 8'hFF);
    tick(); tick();
    chk("wrap_data", 32'(instr_data), 16'hABCD);
    chk("wrap_pc", 32'(instr_pc), 8'hFE);
    tick();
    chk("wrap_next_addr", 32'(mem_addr), 8'h00);
    tick();
    chk("wrap_next_lo", 32'(mem_addr), 8'h01);
    tick(); tick();
    chk("wrap_next_data", 32'(instr_data), 16'h21FE);
    chk("wrap_next_pc", 32'(instr_pc), 8'h00);

`ifndef FETCH_ALIGN_CHECK_EN
    // Unaligned fetch from 0xFF wraps its low byte to 0x00.
    br_valid = 1'b1; br_target = 8'hFF;
    tick(); br_valid = 1'b0;
    chk("odd_hi_addr", 32'(mem_addr), 8'hFF);
    tick();
    chk("odd_lo_addr", 32'(mem_addr), 8'h00);
    tick(); tick();
    chk("odd_data", 32'(instr_data), 16'hCD21);
    chk("odd_pc", 32'(instr_pc), 8'hFF);
    tick();
    chk("odd_next_addr", 32'(mem_addr), 8'h01);
    chk("odd_next_en", 32'(mem_rd_en), 1);
`endif

    // Halt word at 0x3E.
    br_valid = 1'b1; br_target = 8'h3E;
    tick(); br_valid = 1'b0;
    chk("halt_hi_addr", 32'(mem_addr), 8'h3E);
    tick();
    chk("halt_lo_addr", 32'(mem_addr), 8'h3F);
    tick();
    chk("halt_cap_valid", 32'(instr_valid), 0);
    tick();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_valid", 32'(instr_valid), 0);
    chk("halt_rd_en", 32'(mem_rd_en), 0);
    for (int i = 0; i < 4; i++) begin
      start = i[0]; br_valid = ~i[0]; br_target = 8'h00;
      tick();
      chk("halt_hold_rd_en", 32'(mem_rd_en), 0);
      chk("halt_hold_halted", 32'(halted), 1);
      chk("halt_hold_valid", 32'(instr_valid), 0);
    end
    start = 1'b0; br_valid = 1'b0;

    // Reset in the middle of a fetch.
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("mid_lo_addr", 32'(mem_addr), 8'h01);
    reset = 1'b1;
    tick();
    chk_zero("midreset");
    reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("post_reset_addr", 32'(mem_addr), 8'h00);
    chk("post_reset_en", 32'(mem_rd_en), 1);

`ifdef FETCH_ALIGN_CHECK_EN
    br_valid = 1'b1; br_target = 8'h05;
    tick(); br_valid = 1'b0;
    chk("align_err", 32'(addr_err), 1);
    chk("align_halted", 32'(halted), 1);
    chk("align_rd_en", 32'(mem_rd_en), 0);
    chk("align_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("align_hold_rd_en", 32'(mem_rd_en), 0);
    chk("align_hold_err", 32'(addr_err), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences instruction fetch from the byte-wide instruction memory, which holds each 16-bit instruction as a high byte at the even address and a low byte at the next address. The block owns the program counter (PC) and issues two byte reads per instruction. It assembles the 16-bit word and presents it to decode over a valid/ready handshake. It also handles branch redirects and halt detection, and sits between the instruction memory and the decode/control stage.

Parameters:
ADDR_W, 8, width of the PC and the memory address.
RESET_PC, 8'h00, PC value loaded on reset.
HALT_WORD, 16'h0000, instruction encoding that stops fetch.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins fetching from the current PC when in IDLE.
mem_rd_en  output  1  memory read strobe.
mem_addr  output  ADDR_W  memory byte address.
mem_rdata  input  8  read data, valid exactly one cycle after the cycle in which mem_rd_en=1.
instr_valid  output  1  instr_data and instr_pc are valid.
instr_ready  input  1  decode accepts the instruction.
instr_data  output  16  assembled instruction {hi, lo}.
instr_pc  output  ADDR_W  address of the high byte of instr_data.
br_valid  input  1  redirect request.
br_target  input  ADDR_W  redirect address.
halted  output  1  HALT_WORD fetched; fetch stopped.
busy  output  1  high in every state except IDLE and HALTED.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, pc=RESET_PC.
  - mem_rd_en=0, mem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, halted=0, busy=0.
  - reset has priority over every other input, including when asserted mid-fetch.
- States and transitions:
  - IDLE: start=1 -> RD_HI; all other inputs ignored.
  - RD_HI: mem_rd_en=1, mem_addr=pc -> RD_LO.
  - RD_LO: hi_byte<=mem_rdata; mem_rd_en=1, mem_addr=pc+1 -> CAP.
  - CAP: lo_byte<=mem_rdata.
    - If {hi_byte, mem_rdata}==HALT_WORD -> HALTED; the halt word is never presented to decode.
    - Otherwise instr_data<={hi_byte, mem_rdata}, instr_pc<=pc, instr_valid<=1 -> PRESENT.
  - PRESENT: outputs held stable while instr_ready=0. On instr_valid&&instr_ready: instr_valid<=0, pc<=pc+2 -> RD_HI.
  - HALTED: halted=1, mem_rd_en=0. Stays here until reset; start and br_valid are ignored.
- mem_rd_en is 0 in IDLE, CAP, PRESENT and HALTED.
- Latency: start sampled at cycle 0 -> instr_valid=1 in cycle 3 (outputs registered). Back-to-back throughput is one instruction per 4 cycles with instr_ready held high.
- Branch redirect, accepted in RD_HI, RD_LO, CAP and PRESENT:
  - pc<=br_target, instr_valid<=0, any in-flight byte discarded -> RD_HI.
  - Redirect beats a simultaneous instr_ready handshake: the presented instruction counts as consumed and no pc+2 occurs.
  - Redirect beats halt detection in CAP.
  - br_valid is ignored in IDLE and HALTED.
- Arithmetic: pc+1 and pc+2 are modulo 2^ADDR_W.
  - pc=8'hFE: low byte read from 8'hFF, next pc=8'h00.
  - pc=8'hFF: low byte read from 8'h00, next pc=8'h01.
- instr_data and instr_pc must not change while instr_valid=1 and instr_ready=0.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: adds output port addr_err (1 bit, reset 0).
  - A redirect with br_target[0]=1 is not applied: addr_err<=1 (sticky until reset), instr_valid<=0 -> HALTED, halted=1.
  - An even br_target behaves as normal.
- Undefined: no addr_err port. Odd targets are accepted and fetched unaligned (hi byte from the odd address, lo byte from address+1).

Test Plan:
- Memory at 0..3 = 21 FE 22 FB; reset, then start; instr_ready=1 -> instr_data=16'h21FE, instr_pc=0 at cycle 3; 16'h22FB, instr_pc=2 at cycle 7; mem_addr sequence 0,1,2,3.
- instr_ready=0 for 5 cycles while instr_data=16'h21FE is presented -> outputs stable, mem_rd_en=0, pc unchanged; ready=1 -> next fetch at addr 2.
- Bytes 00 00 at addr 62 -> halted=1 and busy=0 after CAP, instr_valid never asserted for that word; later start and br_valid pulses -> no memory reads.
- br_valid=1, br_target=8'h28 during RD_LO -> next mem_addr=8'h28, the partially read instruction is never presented; br_valid coincident with the instr_ready handshake -> fetch at 8'h28, not pc+2.
- pc=8'hFE -> reads at FE, FF, then 00; instr_pc=8'hFE, then 8'h00.
- Reset asserted during RD_LO -> next cycle state IDLE, all outputs 0, pc=RESET_PC. With FETCH_ALIGN_CHECK_EN: br_target=8'h05 -> addr_err=1, halted=1, no reads.
